mem_arbiter: RTL

//  Shares the core's single memory port between instruction fetch (I) and load/store (D).

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one memory port between instruction fetch (I)
// and load/store (D). D has priority, but after STARVE_LIMIT back-to-back D grants
// with I waiting, I is served next. A watchdog aborts accesses that stall too long.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_RVALID,
  output logic [31:0] I_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [3:0]  D_WSTRB,
  input  logic [31:0] D_WDATA,
  output logic        D_RVALID,
  output logic [31:0] D_RDATA,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [3:0]  M_WSTRB,
  output logic [31:0] M_WDATA,
  input  logic        M_ACK,
  input  logic [31:0] M_RDATA,
  output logic        STALL,
  output logic        ERR
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusyI = 2'd1;
  localparam logic [1:0] StBusyD = 2'd2;

  localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);
  localparam logic [7:0] TimeoutCnt  = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        i_rvalid_q, i_rvalid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;

  // Arbitration, memory handshake, watchdog and completion next-state logic
  always_comb begin
    state_d      = state_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wstrb_d    = m_wstrb_q;
    m_wdata_d    = m_wdata_q;
    i_rvalid_d   = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rvalid_d   = 1'b0;
    d_rdata_d    = d_rdata_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;

    case (state_q)
      StIdle: begin
        // The RVALID cycle is skipped: the finishing requester's REQ is still high
        if (!i_rvalid_q && !d_rvalid_q) begin
          if (D_REQ && (!I_REQ || (starve_cnt_q < StarveLimit))) begin
            state_d    = StBusyD;
            m_req_d    = 1'b1;
            m_we_d     = D_WE;
            m_addr_d   = D_ADDR;
            m_wstrb_d  = D_WE ? D_WSTRB : 4'b0000;
            m_wdata_d  = D_WDATA;
            wait_cnt_d = 8'd0;
            if (!I_REQ) begin
              starve_cnt_d = 8'd0;
            end else if (starve_cnt_q != 8'hFF) begin
              starve_cnt_d = starve_cnt_q + 8'd1;
            end
          end else if (I_REQ) begin
            state_d      = StBusyI;
            m_req_d      = 1'b1;
            m_we_d       = 1'b0;
            m_addr_d     = I_ADDR;
            m_wstrb_d    = 4'b0000;
            m_wdata_d    = 32'd0;
            wait_cnt_d   = 8'd0;
            starve_cnt_d = 8'd0;
          end
        end
      end
      StBusyI, StBusyD: begin
        // A late M_ACK on the timeout cycle still counts as a normal completion
        if (M_ACK || (wait_cnt_q == TimeoutCnt)) begin
          state_d = StIdle;
          m_req_d = 1'b0;
          if (state_q == StBusyI) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = M_ACK ? M_RDATA : 32'd0;
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = (M_ACK && !m_we_q) ? M_RDATA : 32'd0;
          end
          if (!M_ACK) begin
            err_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= 32'd0;
      m_wstrb_q    <= 4'b0000;
      m_wdata_q    <= 32'd0;
      i_rvalid_q   <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= 32'd0;
      starve_cnt_q <= 8'd0;
      wait_cnt_q   <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wstrb_q    <= m_wstrb_d;
      m_wdata_q    <= m_wdata_d;
      i_rvalid_q   <= i_rvalid_d;
      i_rdata_q    <= i_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
    end
  end

  // Pipeline stall is combinational so the latches freeze in the request cycle itself
  always_comb begin
    STALL = RST & ((I_REQ & ~i_rvalid_q) | (D_REQ & ~d_rvalid_q));
  end

  assign M_REQ    = m_req_q;
  assign M_WE     = m_we_q;
  assign M_ADDR   = m_addr_q;
  assign M_WSTRB  = m_wstrb_q;
  assign M_WDATA  = m_wdata_q;
  assign I_RVALID = i_rvalid_q;
  assign I_RDATA  = i_rdata_q;
  assign D_RVALID = d_rvalid_q;
  assign D_RDATA  = d_rdata_q;
  assign ERR      = err_q;

endmodule
